// File: rtl/serial_add_sub_multi.sv
// Multi-channel digit-serial adder/subtractor (LSB digit first) with per-word framing and
// deserialisation of each result into a parallel word with carry-out and overflow flags.
module serial_add_sub_multi #(
  parameter int unsigned CHANNELS    = 2,
  parameter int unsigned DIGIT_W     = 1,
  parameter int unsigned WORD_DIGITS = 8,
  localparam int unsigned IdxW  = (WORD_DIGITS > 1) ? $clog2(WORD_DIGITS) : 1,
  localparam int unsigned WordW = DIGIT_W * WORD_DIGITS
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid_i,
  input  logic [CHANNELS-1:0]             sub_i,
  input  logic [CHANNELS*DIGIT_W-1:0]     a_i,
  input  logic [CHANNELS*DIGIT_W-1:0]     b_i,
  output logic [IdxW-1:0]                 digit_idx_o,
  output logic                            out_valid_o,
  output logic [CHANNELS*DIGIT_W-1:0]     sum_o,
  output logic                            word_valid_o,
  output logic [CHANNELS*WordW-1:0]       word_o,
  output logic [CHANNELS-1:0]             carry_out_o,
  output logic [CHANNELS-1:0]             overflow_o
);

  logic [IdxW-1:0]                cnt_q, cnt_d;
  logic [CHANNELS-1:0]            carry_q, carry_d;
  logic [CHANNELS-1:0]            mode_q, mode_d;
  logic [CHANNELS*WordW-1:0]      shadow_q, shadow_d;
  logic [CHANNELS*WordW-1:0]      word_q, word_d;
  logic [CHANNELS*DIGIT_W-1:0]    sum_q, sum_d;
  logic [CHANNELS-1:0]            carry_out_q, carry_out_d;
  logic [CHANNELS-1:0]            overflow_q, overflow_d;
  logic                           out_valid_q, word_valid_q;

  logic                           first_digit, last_digit;
  logic [CHANNELS-1:0]            sub_eff, cin, ovf_dig;
  logic [CHANNELS*DIGIT_W-1:0]    b_eff;
  logic [DIGIT_W:0]               res [CHANNELS];

  assign first_digit = (cnt_q == '0);
  assign last_digit  = (cnt_q == IdxW'(WORD_DIGITS - 1));

  // Digit 0 takes mode and initial carry straight from sub_i; later digits use the latched mode.
  always_comb begin
    sub_eff = '0;
    cin     = '0;
    ovf_dig = '0;
    b_eff   = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      res[k] = '0;
    end
    for (int k = 0; k < CHANNELS; k++) begin
      sub_eff[k] = first_digit ? sub_i[k] : mode_q[k];
      cin[k]     = first_digit ? sub_i[k] : carry_q[k];
      b_eff[k*DIGIT_W +: DIGIT_W] = b_i[k*DIGIT_W +: DIGIT_W] ^ {DIGIT_W{sub_eff[k]}};
      res[k] = {1'b0, a_i[k*DIGIT_W +: DIGIT_W]} + {1'b0, b_eff[k*DIGIT_W +: DIGIT_W]}
             + {{DIGIT_W{1'b0}}, cin[k]};
      // Same-sign operands producing a different-sign result == carry-in XOR carry-out of MSB.
      ovf_dig[k] = (a_i[k*DIGIT_W + DIGIT_W - 1] == b_eff[k*DIGIT_W + DIGIT_W - 1]) &&
                   (res[k][DIGIT_W-1] != a_i[k*DIGIT_W + DIGIT_W - 1]);
    end
  end

  always_comb begin
    cnt_d       = cnt_q;
    carry_d     = carry_q;
    mode_d      = mode_q;
    shadow_d    = shadow_q;
    sum_d       = sum_q;
    word_d      = word_q;
    carry_out_d = carry_out_q;
    overflow_d  = overflow_q;
    if (in_valid_i) begin
      cnt_d  = last_digit ? '0 : cnt_q + IdxW'(1);
      mode_d = sub_eff;
      for (int k = 0; k < CHANNELS; k++) begin
        carry_d[k] = res[k][DIGIT_W];
        sum_d[k*DIGIT_W +: DIGIT_W] = res[k][DIGIT_W-1:0];
        shadow_d[k*WordW + int'(cnt_q)*DIGIT_W +: DIGIT_W] = res[k][DIGIT_W-1:0];
      end
      if (last_digit) begin
        word_d      = shadow_d;
        carry_out_d = carry_d;
        overflow_d  = ovf_dig;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q        <= '0;
      carry_q      <= '0;
      mode_q       <= '0;
      shadow_q     <= '0;
      sum_q        <= '0;
      word_q       <= '0;
      carry_out_q  <= '0;
      overflow_q   <= '0;
      out_valid_q  <= 1'b0;
      word_valid_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      carry_q      <= carry_d;
      mode_q       <= mode_d;
      shadow_q     <= shadow_d;
      sum_q        <= sum_d;
      word_q       <= word_d;
      carry_out_q  <= carry_out_d;
      overflow_q   <= overflow_d;
      out_valid_q  <= in_valid_i;
      word_valid_q <= in_valid_i && last_digit;
    end
  end

  assign digit_idx_o  = cnt_q;
  assign out_valid_o  = out_valid_q;
  assign sum_o        = sum_q;
  assign word_valid_o = word_valid_q;
  assign word_o       = word_q;
  assign carry_out_o  = carry_out_q;
  assign overflow_o   = overflow_q;

endmodule

// File: doc/serial_add_sub_multi.md
Name: serial_add_sub_multi

Overview:
- Multi-channel, digit-serial adder/subtractor, LSB digit first; one DIGIT_W-bit digit per channel per accepted cycle.
- Words are framed internally by a digit counter; carry/borrow state is per channel and re-initialised every word.
- Also deserialises each result into a parallel word with final carry-out and signed-overflow flags.
- Sits between serial links and parallel datapath logic in the sequential-basics family.

Parameters:
CHANNELS, 2, number of independent lanes sharing framing/handshake
DIGIT_W, 1, bits per digit per cycle (1 = bit-serial)
WORD_DIGITS, 8, digits per word; word width = DIGIT_W*WORD_DIGITS

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-low
in_valid  input  1  digit on a/b/sub accepted this cycle
sub  input  CHANNELS  per-channel mode (1 = a-b); sampled only at digit 0
a  input  CHANNELS*DIGIT_W  operand A digits, channel k at [k*DIGIT_W +: DIGIT_W]
b  input  CHANNELS*DIGIT_W  operand B digits, same packing
digit_idx  output  $clog2(WORD_DIGITS) (min 1)  index of next digit to be accepted
out_valid  output  1  sum valid, one cycle after accepted digit
sum  output  CHANNELS*DIGIT_W  result digits
word_valid  output  1  one-cycle pulse: word/carry_out/overflow updated
word  output  CHANNELS*DIGIT_W*WORD_DIGITS  assembled results, channel k at [k*W +: W]
carry_out  output  CHANNELS  final carry of word (sub: 1 = no borrow)
overflow  output  CHANNELS  two's-complement overflow of word

Behaviour:
- Reset (rst=0, async): digit counter 0, carries 0, latched modes 0, partial words cleared; out_valid, sum, word_valid, word, carry_out, overflow all 0.
- Accept: digit accepted on a rising clk edge with in_valid=1; counter increments, wraps WORD_DIGITS-1 -> 0.
- Digit 0: latch sub[k] per channel; incoming carry = sub[k]. Later changes of sub within the word are ignored.
- Per digit per channel: b' = latched_sub ? ~b : b; {c_next, s} = a + b' + carry (DIGIT_W+1 bits); carry <= c_next.
- Latency 1: sum and out_valid registered; out_valid=1 in the cycle after each accepted digit, else 0. sum holds last value when out_valid=0.
- Stall: in_valid=0 freezes counter, carries, modes and partial word. No timeout.
- Assembly: digit i result stored at bits [i*DIGIT_W +: DIGIT_W] of the channel's shadow word.
- Word completion: on acceptance of digit WORD_DIGITS-1, next cycle: word_valid=1 coincident with that digit's out_valid.
  - word = full shadow word including the last digit.
  - carry_out = c_next of the last digit.
  - overflow = carry into word MSB XOR carry out of word MSB.
- word, carry_out, overflow hold until the next word_valid. Back-to-back words need no idle cycle; no carry leaks across words.
- digit_idx reflects the registered counter (0 after reset and after each word).
- Reset mid-word: partial word discarded, no word_valid. First digit after release is digit 0.

Test Plan:
- Add, defaults: ch0 0x81+0x84, ch1 0x12+0x34, sub=0, 8 consecutive valid cycles -> 8 out_valid pulses; word_valid once with ch0 word 0x05, carry_out 1, overflow 1; ch1 0x46, carry_out 0, overflow 0.
- Subtract: ch0 0x10-0x20 -> 0xF0, carry_out 0, ovf 0; ch1 0x80-0x01 -> 0x7F, carry_out 1, ovf 1; serial sum bits match word LSB-first.
- Stall: same as scenario 1 with in_valid low 3 cycles after digit 3 -> identical results; out_valid gap of 3; single word_valid; digit_idx held at 4 during stall.
- Back-to-back: ch0 0xFF+0x01 then immediately 0x00+0x00 -> words 0x00 (carry 1) then 0x00 (carry 0); word_valid in two cycles 8 apart.
- Reset mid-word: rst low after 3 digits -> all outputs 0, digit_idx 0, no word_valid; full word 0x12+0x34 afterwards -> 0x46.
- DIGIT_W=4, WORD_DIGITS=4: 0xBEEF+0x1111 -> 0xD000, carry 0, ovf 0. Toggling sub at digit 2 is ignored (still add).
